// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants, FSM states, baud divisors and parity helper
package uart_pkg;
   localparam int CLK_HZ     = 50_000_000;
   localparam int DATA_BITS  = 8;
   localparam int OVERSAMPLE = 16;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;

   function automatic int unsigned div_of(input int unsigned baud);
      return (CLK_HZ + 8 * baud) / (OVERSAMPLE * baud);
   endfunction

   localparam int unsigned DIV [0:7] = '{div_of(300), div_of(1200), div_of(4800), div_of(9600),
                                          div_of(19200), div_of(38400), div_of(57600), div_of(115200)};

   function automatic logic parity8(input logic [7:0] d);
      return ^d;
   endfunction
endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: one-clk sample enable every DIV[baud_sel] clocks, restarted by clear or a rate change
module uart_tick_gen
   import uart_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] baud_sel,
   input  logic       clear,
   output logic       tick
);
   logic [13:0] cnt;
   logic [2:0]  sel_q;
   logic        restart;

   always_comb begin
      restart = clear || (baud_sel != sel_q);
      tick    = !restart && (cnt == 14'(DIV[baud_sel] - 32'd1));
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         cnt   <= '0;
         sel_q <= '0;
      end else begin
         sel_q <= baud_sel;
         cnt   <= (restart || tick) ? '0 : cnt + 14'd1;
      end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x oversampled 8-bit even-parity UART receiver with parity/framing error flags
module uart_receiver
   import uart_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       Rx_EN,
   input  logic       RxD,
   input  logic [2:0] baud_sel,
   output logic [7:0] Rx_DATA,
   output logic       Rx_VALID,
   output logic       Rx_PERROR,
   output logic       Rx_FERROR,
   output logic       Rx_BUSY
);
   rx_state_t  state, state_nx;
   logic       rx_meta, rxs, rxs_q;
   logic       tick, mid, last, vote;
   logic [3:0] s_cnt, s_cnt_nx;
   logic [2:0] idx, idx_nx;
   logic [1:0] smp, smp_nx;
   logic [7:0] shreg, shreg_nx, data_nx;
   logic       par, par_nx, valid_nx, perr_nx, ferr_nx, busy_nx;

   uart_tick_gen u_tick (
      .clk      (clk),
      .reset    (reset),
      .baud_sel (baud_sel),
      .clear    (state == IDLE),
      .tick     (tick)
   );

   always_comb begin
      mid      = tick && (s_cnt == 4'd9);
      last     = tick && (s_cnt == 4'(OVERSAMPLE - 1));
      vote     = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
      state_nx = state;
      s_cnt_nx = tick ? s_cnt + 4'd1 : s_cnt;
      idx_nx   = idx;
      smp_nx   = smp;
      shreg_nx = shreg;
      par_nx   = par;
      data_nx  = Rx_DATA;
      valid_nx = 1'b0;
      perr_nx  = Rx_PERROR;
      ferr_nx  = Rx_FERROR;
      busy_nx  = Rx_BUSY;
      if (tick && s_cnt == 4'd7) smp_nx[0] = rxs;
      if (tick && s_cnt == 4'd8) smp_nx[1] = rxs;
      if (!Rx_EN) begin
         state_nx = IDLE;
         busy_nx  = 1'b0;
      end else
         case (state)
            IDLE:
               if (rxs_q && !rxs) begin
                  state_nx = START;
                  s_cnt_nx = '0;
                  perr_nx  = 1'b0;
                  ferr_nx  = 1'b0;
                  busy_nx  = 1'b1;
               end
            START:
               if (mid && vote) begin
                  state_nx = IDLE;
                  busy_nx  = 1'b0;
               end else if (last) begin
                  state_nx = DATA;
                  idx_nx   = '0;
               end
            DATA: begin
               if (mid) shreg_nx = {vote, shreg[7:1]};
               if (last) begin
                  idx_nx = idx + 3'd1;
                  if (idx == 3'(DATA_BITS - 1)) state_nx = PARITY;
               end
            end
            PARITY: begin
               if (mid) par_nx = vote;
               if (last) state_nx = STOP;
            end
            STOP:
               if (mid) begin
                  data_nx  = shreg;
                  perr_nx  = par != parity8(shreg);
                  ferr_nx  = !vote;
                  valid_nx = vote && (par == parity8(shreg));
                  busy_nx  = 1'b0;
                  state_nx = vote ? IDLE : BREAK;
               end
            BREAK:
               if (rxs) state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         rx_meta   <= 1'b1;
         rxs       <= 1'b1;
         rxs_q     <= 1'b1;
         state     <= IDLE;
         s_cnt     <= '0;
         idx       <= '0;
         smp       <= '0;
         shreg     <= '0;
         par       <= 1'b0;
         Rx_DATA   <= '0;
         Rx_VALID  <= 1'b0;
         Rx_PERROR <= 1'b0;
         Rx_FERROR <= 1'b0;
         Rx_BUSY   <= 1'b0;
      end else begin
         rx_meta   <= RxD;
         rxs       <= rx_meta;
         rxs_q     <= rxs;
         state     <= state_nx;
         s_cnt     <= s_cnt_nx;
         idx       <= idx_nx;
         smp       <= smp_nx;
         shreg     <= shreg_nx;
         par       <= par_nx;
         Rx_DATA   <= data_nx;
         Rx_VALID  <= valid_nx;
         Rx_PERROR <= perr_nx;
         Rx_FERROR <= ferr_nx;
         Rx_BUSY   <= busy_nx;
      end
endmodule
